// File: rtl/remote_comm.sv
// UART command link to the copter: 3-byte 8N1 command frames out on TX,
// single-byte responses in on RX, each side with its own baud timing.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [3:0] LAST_BIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_MID,
    SEND_LO
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_DATA
  } rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic [7:0]    cmd_q;
  logic [15:0]   data_q;
  logic          tx_q;
  logic          busy_q;
  logic          cmd_sent_q;

  logic          tx_accept;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_bit_nx;

  assign tx_accept = (tx_state_q == IDLE) && snd_cmd;
  assign tx_bit_nx = tx_bit_q + 4'd1;
  assign tx_frame  = {1'b1, tx_byte, 1'b0};

  always_comb begin
    tx_byte = cmd_q;
    unique case (tx_state_q)
      SEND_MID: tx_byte = data_q[15:8];
      SEND_LO:  tx_byte = data_q[7:0];
      default:  tx_byte = cmd_q;
    endcase
  end

  // Bit index 0 is start, 1..8 data LSB first, 9 stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
    end else begin
      cmd_sent_q <= 1'b0;
      unique case (tx_state_q)
        IDLE: begin
          if (snd_cmd) begin
            cmd_q      <= cmd;
            data_q     <= data;
            tx_state_q <= SEND_HI;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          if (tx_baud_q != BAUD_MAX) begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end else begin
            tx_baud_q <= '0;
            if (tx_bit_q != LAST_BIT) begin
              tx_bit_q <= tx_bit_nx;
              tx_q     <= tx_frame[tx_bit_nx];
            end else begin
              tx_bit_q <= '0;
              unique case (tx_state_q)
                SEND_HI: begin
                  tx_state_q <= SEND_MID;
                  tx_q       <= 1'b0;
                end
                SEND_MID: begin
                  tx_state_q <= SEND_LO;
                  tx_q       <= 1'b0;
                end
                default: begin
                  tx_state_q <= IDLE;
                  tx_q       <= 1'b1;
                  busy_q     <= 1'b0;
                  cmd_sent_q <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic          rx_s1_q;
  logic          rx_s2_q;
  logic          rx_s3_q;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_baud_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    resp_q;
  logic          resp_rdy_q;
  logic          resp_rdy_d;

  logic          rx_mid;
  logic          rx_byte_ok;

  assign rx_mid     = (rx_state_q == RX_DATA) && (rx_baud_q == BAUD_HALF);
  assign rx_byte_ok = rx_mid && (rx_bit_q == LAST_BIT) && rx_s2_q;

  // rx_s3_q only serves falling-edge detection on the synchronized line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s2_q && rx_s3_q) begin
            rx_state_q <= RX_DATA;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
          end
        end
        default: begin
          if (rx_baud_q == BAUD_MAX) begin
            rx_baud_q <= '0;
            rx_bit_q  <= rx_bit_q + 4'd1;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
          if (rx_mid) begin
            if (rx_bit_q == 4'd0) begin
              if (rx_s2_q) begin
                rx_state_q <= RX_IDLE;
                rx_baud_q  <= '0;
              end
            end else if (rx_bit_q == LAST_BIT) begin
              rx_state_q <= RX_IDLE;
              rx_baud_q  <= '0;
              rx_bit_q   <= '0;
              if (rx_s2_q) begin
                resp_q <= rx_shift_q;
              end
            end else begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    resp_rdy_d = resp_rdy_q;
    if (rx_byte_ok) begin
      resp_rdy_d = 1'b1;
    end else if (tx_accept) begin
      resp_rdy_d = 1'b0;
    end else if (clr_resp_rdy) begin
      resp_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdy_q <= 1'b0;
    end else begin
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: TX bytes and RX responses go through
// expectation queues drained by independent line/flag monitors.
module tb_remote_comm;

  localparam int BD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        clr_resp_rdy = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        busy;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sent_cnt = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk          (clk),
    .rst          (rst),
    .snd_cmd      (snd_cmd),
    .cmd          (cmd),
    .data         (data),
    .clr_resp_rdy (clr_resp_rdy),
    .RX           (RX),
    .TX           (TX),
    .busy         (busy),
    .cmd_sent     (cmd_sent),
    .resp         (resp),
    .resp_rdy     (resp_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_sent) sent_cnt <= sent_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX line monitor: decodes 8N1 bytes mid-bit
  logic       tx_prev = 1'b1;
  bit         mact = 1'b0;
  int         mcnt = 0;
  logic [7:0] msh = '0;

  always @(negedge clk) begin
    if (rst) begin
      mact = 1'b0;
      exp_tx.delete();
    end else if (mact) begin
      mcnt++;
      if (mcnt == 4) begin
        check("tx_start_bit", 32'(TX), 32'h0);
      end else if (mcnt >= 12 && mcnt <= 68 && (mcnt % 8) == 4) begin
        msh = {TX, msh[7:1]};
      end else if (mcnt == 76) begin
        check("tx_stop_bit", 32'(TX), 32'h1);
        mact = 1'b0;
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got byte %0h expected none", msh);
        end else begin
          check("tx_byte", 32'(msh), 32'(exp_tx.pop_front()));
        end
      end
    end else if (tx_prev && !TX) begin
      mact = 1'b1;
      mcnt = 0;
    end
    tx_prev = TX;
  end

  // resp monitor: every rising resp_rdy must match the next expected byte
  logic rdy_prev = 1'b0;

  always @(negedge clk) begin
    if (resp_rdy && !rdy_prev) begin
      if (exp_rx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got resp %0h expected none", resp);
      end else begin
        check("rx_resp", 32'(resp), 32'(exp_rx.pop_front()));
      end
    end
    rdy_prev = resp_rdy;
  end

  // Called at a negedge; drives snd_cmd immediately, returns at the
  // negedge where cmd_sent is seen (so a chained call hits that cycle).
  task automatic tx_frame(input logic [7:0] c, input logic [15:0] d,
                          input int inj, input bit chk_rdy);
    int c0;
    int lat;
    bit bl;
    exp_tx.push_back(c);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
    snd_cmd = 1'b1;
    cmd = c;
    data = d;
    @(negedge clk);
    snd_cmd = 1'b0;
    c0 = cyc;
    lat = -1;
    bl = 1'b0;
    if (chk_rdy) check("rdy_clr_on_send", 32'(resp_rdy), 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (cmd_sent) begin
        lat = cyc - c0;
        break;
      end
      if (!busy) bl = 1'b1;
      if (cyc - c0 == inj) begin
        snd_cmd = 1'b1;
        cmd = 8'hFF;
        data = 16'hFFFF;
      end else begin
        snd_cmd = 1'b0;
      end
      @(negedge clk);
    end
    snd_cmd = 1'b0;
    check("cmd_sent_latency", 32'(lat), 32'(30 * BD));
    check("busy_through_frame", 32'(bl), 32'h0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[0];
      f = f >> 1;
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd_sent", 32'(cmd_sent), 32'h0);
    check("rst_resp", 32'(resp), 32'h0);
    check("rst_resp_rdy", 32'(resp_rdy), 32'h0);

    rst = 1'b0;
    tx_frame(8'h05, 16'hA53C, -1, 1'b0);

    repeat (5) @(negedge clk);
    s = sent_cnt;
    tx_frame(8'h12, 16'h3456, 100, 1'b0);
    repeat (5) @(negedge clk);
    check("single_pulse", 32'(sent_cnt - s), 32'h1);

    s = sent_cnt;
    tx_frame(8'hC0, 16'hFFEE, -1, 1'b0);
    tx_frame(8'h3A, 16'h0102, -1, 1'b0);
    repeat (5) @(negedge clk);
    check("chained_pulses", 32'(sent_cnt - s), 32'h2);

    exp_rx.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    check("rdy_set", 32'(resp_rdy), 32'h1);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    check("rdy_cleared", 32'(resp_rdy), 32'h0);

    send_rx(8'h3C, 1'b0);
    check("frame_err_resp", 32'(resp), 32'hA5);
    check("frame_err_rdy", 32'(resp_rdy), 32'h0);

    clr_resp_rdy = 1'b1;
    exp_rx.push_back(8'h5A);
    fork
      send_rx(8'h5A, 1'b1);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (resp_rdy) begin
            seen = 1'b1;
            break;
          end
        end
        clr_resp_rdy = 1'b0;
        check("set_beats_clr", 32'(seen), 32'h1);
      end
    join
    check("rdy_held", 32'(resp_rdy), 32'h1);
    tx_frame(8'h9C, 16'h0F0F, -1, 1'b1);

    repeat (5) @(negedge clk);
    exp_rx.push_back(8'hC3);
    fork
      tx_frame(8'h66, 16'h9966, -1, 1'b0);
      begin
        repeat (20) @(negedge clk);
        send_rx(8'hC3, 1'b1);
      end
    join
    check("rx_during_tx", 32'(resp), 32'hC3);

    repeat (5) @(negedge clk);
    s = sent_cnt;
    snd_cmd = 1'b1;
    cmd = 8'h00;
    data = 16'h0000;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (50) @(negedge clk);
    check("tx_low_pre_rst", 32'(TX), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_abort_tx", 32'(TX), 32'h1);
    check("rst_abort_busy", 32'(busy), 32'h0);
    check("rst_clears_resp", 32'(resp), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (260) @(negedge clk);
    check("no_sent_after_rst", 32'(sent_cnt - s), 32'h0);
    tx_frame(8'h81, 16'h7E18, -1, 1'b0);

    repeat (10) @(negedge clk);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'h0);
    check("rx_queue_empty", 32'(exp_rx.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             tests, fails);
    $finish;
  end

endmodule
